mul_div_unit: RTL
=================

# mul_div_unit

Iterative multiply/divide unit implementing the RISC-V M-extension operations for the execute stage, alongside the single-cycle `alu`. It is the parametrised, sequential successor to the ALU's `Mul_ext_i` path. Width is set by `XLEN`. The unit computes one product or quotient bit per cycle and presents results through a valid/ready handshake, so the pipeline stalls on `ready_o`/`valid_o` instead of holding a long combinational path.

## Interface
- `XLEN`, 32, operand/result width (≥ 8, even)
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `valid_i`  in  1  request valid
- `ready_o`  out  1  unit can accept a request (IDLE only)
- `op_i`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_i`  in  XLEN  operand A (dividend / multiplicand)
- `rs2_i`  in  XLEN  operand B (divisor / multiplier)
- `kill_i`  in  1  pipeline flush; aborts any in-flight operation
- `valid_o`  out  1  `result_o` valid
- `ready_i`  in  1  consumer takes result
- `result_o`  out  XLEN  result
- `busy_o`  out  1  high in CALC or FIX

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: `valid_i & ready_o & !kill_i` at a rising edge. The unit latches `op_i`, `rs1_i`, and `rs2_i`, then takes the operand magnitudes and sign flags.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: `rs1_i` signed, `rs2_i` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply: shift-add on magnitudes, 2·XLEN-bit accumulator, one multiplier bit per CALC cycle.
- Divide: restoring division on magnitudes, one quotient bit per CALC cycle. The partial remainder is XLEN+1 bits.
- IDLE → CALC on accept (normal case).
- CALC runs exactly XLEN cycles (iteration counter 0..XLEN-1), then → FIX.
- FIX:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Select the result: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - FIX → DONE.
- Special cases are resolved at accept and go IDLE → DONE directly:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return `rs1_i`.
  - Signed overflow (DIV/REM with `rs1_i` = most-negative and `rs2_i` = all ones): DIV returns the most-negative value; REM returns 0.
- DONE: `valid_o` = 1, `result_o` held stable. Leaves to IDLE on `ready_i`.
- `kill_i` in CALC, FIX or DONE returns the unit to IDLE at the next edge with no `valid_o` pulse. In IDLE, `kill_i` blocks acceptance (kill wins over `valid_i`).
- Async reset at any time returns to IDLE immediately. All in-flight state is discarded.

## Timing
- Reset values: `ready_o` = 1, `valid_o` = 0, `busy_o` = 0, `result_o` = 0, state = IDLE, counter = 0.
- `ready_o` = 1 only in IDLE. No request overlap; at most one operation is in flight.
- Normal latency: `valid_o` rises XLEN+2 edges after the accepting edge (34 for XLEN = 32).
- Special-case latency: `valid_o` rises 1 edge after the accepting edge.
- `valid_o` and `ready_i` both high at an edge: handshake complete. `ready_o` rises after that edge, so a new request is accepted no earlier than the following edge (minimum 1 IDLE cycle between results).
- `valid_o` high with `ready_i` low: `result_o`, `valid_o` and `ready_o` = 0 hold indefinitely.
- `result_o` retains its last value outside DONE. It is cleared only by reset.
- Input operands are sampled only at accept; they may change freely afterwards.
- All outputs are registered.

## Test plan
- **MUL, XLEN = 32:** MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. `valid_o` exactly 34 cycles after accept; `busy_o` high for 33 cycles.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Divide:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- **Special cases, each with `valid_o` 1 cycle after accept:**
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- **Backpressure and back-to-back:**
  - Hold `ready_i` = 0 for 5 cycles after `valid_o` → `result_o` stable, `ready_o` = 0.
  - Release `ready_i` → `ready_o` = 1 on the next cycle.
  - Back-to-back requests are accepted correctly.
- **Abort paths:**
  - `kill_i` on cycle 10 of CALC → no `valid_o`, `ready_o` = 1 next cycle, and the next request is correct.
  - `rst_i` mid-CALC → all outputs at reset values before the next edge.
  - Repeat the divide test at XLEN = 16: DIV 0xFFF9 / 2 → 0xFFFD, latency 18.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RISC-V M-extension multiply/divide unit
// One product/quotient bit per cycle; results are handed off through a valid/ready handshake.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(XLEN-1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, next_state;

    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   res;

    logic            accept, signed_a, signed_b, in_a_neg, in_b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, special_res;

    always_comb begin
        accept      = valid_i && (state == IDLE) && !kill_i;
        signed_a    = op_i[2] ? !op_i[0] : !(op_i[1] && op_i[0]);
        signed_b    = op_i[2] ? !op_i[0] : !op_i[1];
        in_a_neg    = signed_a && rs1_i[XLEN-1];
        in_b_neg    = signed_b && rs2_i[XLEN-1];
        mag_a       = in_a_neg ? -rs1_i : rs1_i;
        mag_b       = in_b_neg ? -rs2_i : rs2_i;
        div_zero    = op_i[2] && (rs2_i == '0);
        div_ovf     = op_i[2] && !op_i[0] && (rs1_i == MOST_NEG) && (rs2_i == '1);
        special     = div_zero || div_ovf;
        special_res = div_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : MOST_NEG);
    end

    // acc holds {partial product, multiplier} for MUL ops and {remainder, dividend/quotient} for DIV ops
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff, quo, rem, fix_res;
    logic [2*XLEN-1:0] step_acc, prod;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = XLEN'(div_shift - {1'b0, opb});
        if (op_q[2]) begin
            step_acc = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc[XLEN-1:1]};
        end
        prod = (a_neg ^ b_neg) ? -acc : acc;
        quo  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = special ? DONE : CALC;
            CALC: begin
                if (kill_i)           next_state = IDLE;
                else if (cnt == LAST) next_state = FIX;
            end
            FIX:  next_state = kill_i ? IDLE : DONE;
            DONE: if (kill_i || (valid_o && ready_i)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            opb   <= '0;
            acc   <= '0;
            res   <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q  <= op_i;
                a_neg <= in_a_neg;
                b_neg <= in_b_neg;
                cnt   <= '0;
                if (special) begin
                    res <= special_res;
                end else if (op_i[2]) begin
                    acc <= {{XLEN{1'b0}}, mag_a};
                    opb <= mag_b;
                end else begin
                    acc <= {{XLEN{1'b0}}, mag_b};
                    opb <= mag_a;
                end
            end else if (state == CALC) begin
                cnt <= cnt + CW'(1);
                acc <= step_acc;
            end else if (state == FIX) begin
                res <= fix_res;
            end
        end
    end

    // valid_o trails entry into DONE by one edge; result_o only moves when a result is presented
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            ready_o <= (next_state == IDLE);
            busy_o  <= (next_state == CALC) || (next_state == FIX);
            valid_o <= (state == DONE) && !kill_i && !(valid_o && ready_i);
            if ((state == DONE) && !valid_o && !kill_i) result_o <= res;
        end
    end
endmodule
